uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares the single UART transmitter between up to N_REQ byte sources, e.g. button-triggered echo, hex-dump responder and status reporter.
- Latches the granted byte and issues a one-cycle tx_start to the UART.
- Waits for the UART's tx_done_tick, acknowledges the winning requester, then enforces a programmable idle gap before the next byte.
- Sits between the requester logic and the uart instance at the top level; the UART itself is unchanged.

Parameters:
N_REQ, 4, number of requesters (2..8)
DBIT, 8, data bits per UART frame
GAP_CYCLES, 16, idle clk cycles inserted after each tx_done_tick before the next grant (0 = no gap)
TIMEOUT_CYCLES, 20000, max cycles to wait for tx_done_tick after tx_start (0 = watchdog disabled)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester request level, held until ack
req_data  in  N_REQ*DBIT  byte of requester i in bits [i*DBIT +: DBIT]
ack  out  N_REQ  one-cycle pulse to the served requester
tx_start  out  1  one-cycle start pulse to UART transmitter
tx_data  out  DBIT  byte presented to UART, stable from grant until next grant
tx_done_tick  in  1  UART transmitter frame-complete pulse
busy  out  1  high whenever state != IDLE
grant_id  out  clog2(N_REQ)  index of the current or last granted requester
timeout_err  out  1  one-cycle pulse when the watchdog expires

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr pointer=0, gap and watchdog counters=0.
- All outputs are registered; every output is 0 while in reset.
- States are IDLE, START, WAIT_DONE and GAP.
- IDLE:
  - Scan req cyclically starting at the rr pointer; the first set bit wins.
  - On a win: register grant_id, latch tx_data from that slice, go to START.
  - No req set: stay in IDLE.
- START:
  - tx_start=1 for exactly this one cycle.
  - Load the watchdog with TIMEOUT_CYCLES.
  - Go to WAIT_DONE.
- Latency: req sampled high in IDLE at cycle t gives tx_start high in cycle t+1.
- WAIT_DONE:
  - On tx_done_tick: ack[grant_id]=1 for one cycle and rr pointer = (grant_id+1) mod N_REQ.
  - Then load the gap counter with GAP_CYCLES and go to GAP, or go to IDLE if GAP_CYCLES=0.
  - Watchdog (TIMEOUT_CYCLES>0): decrements each cycle without tx_done_tick. On reaching 0, pulse ack[grant_id] and timeout_err together in the same cycle, advance the pointer exactly as on done, then enter GAP/IDLE.
- GAP: decrement the gap counter; move to IDLE in the cycle after it reads 1. The idle gap is exactly GAP_CYCLES cycles.
- tx_done_tick in IDLE, START or GAP is ignored: no ack, no state change.
- tx_done_tick and watchdog expiry in the same cycle: treat as done; no timeout_err.
- Data is captured only at grant. Changes to req_data after grant do not affect tx_data.
- req dropped after grant: the transfer still completes and ack is still pulsed.
- A requester still holding req in IDLE after its ack is treated as a new request. It still has lowest priority because the pointer has moved past it.
- Pointer wrap: after serving index N_REQ-1 the pointer returns to 0.
- Only one ack bit is ever high in a cycle; ack and tx_start are never high in the same cycle.
- Reset asserted mid-frame: all state clears immediately. The UART's in-flight frame and any late tx_done_tick are ignored because the state is IDLE.

Test Plan:
- Single request: req=4'b0010, data1=8'h41, GAP_CYCLES=16 -> tx_start one cycle after req sampled, tx_data=8'h41, grant_id=1; tx_done_tick -> ack=4'b0010 for 1 cycle; busy stays high for 16 more cycles.
- Contention: req=4'b1111 held, each requester drops req on its ack, bytes 8'h10/11/12/13 -> grant order 0,1,2,3; next req=4'b1001 -> grant 0 then 3.
- Fairness with persistent requester: req0 and req2 held permanently -> grants alternate 0,2,0,2 over 6 transfers, never two consecutive grants to the same index.
- Data stability: change data0 from 8'hAA to 8'h55 one cycle after grant -> tx_data stays 8'hAA until the next grant.
- Watchdog: TIMEOUT_CYCLES=50 and no tx_done_tick -> timeout_err and ack pulse together in cycle 50 after tx_start; a stray tx_done_tick during GAP produces no ack.
- Async reset: assert rst=0 mid-WAIT_DONE -> busy, tx_start, ack and grant_id read 0 immediately; after release with req=4'b0100, grant goes to index 2 with pointer starting at 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ byte sources,
// with a start pulse, done/watchdog completion, per-requester ack and a programmable idle gap.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned DBIT           = 8,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DBIT-1:0]      req_data,
    output logic [N_REQ-1:0]           ack,
    output logic                       tx_start,
    output logic [DBIT-1:0]            tx_data,
    input  logic                       tx_done_tick,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       timeout_err
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr, ptr_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_nxt;
    logic [WD_W-1:0]   wd_cnt, wd_nxt;
    logic [N_REQ-1:0]  ack_nxt;
    logic              tx_start_nxt;
    logic              busy_nxt;
    logic              timeout_nxt;
    logic [DBIT-1:0]   tx_data_nxt;
    logic [ID_W-1:0]   grant_nxt;
    logic              finish;

    logic              found;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   scan_idx;
    logic [DBIT-1:0]   win_data;
    logic [DBIT-1:0]   slot [N_REQ];

    // Split the flat data bus into one byte per requester.
    for (genvar g = 0; g < N_REQ; g++) begin : g_slot
        assign slot[g] = req_data[g*DBIT +: DBIT];
    end

    // Cyclic scan starting at the round-robin pointer; the first set request wins.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = ID_W'((32'(ptr) + k) % N_REQ);
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end
        win_data = slot[win];
    end

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        gap_nxt      = gap_cnt;
        wd_nxt       = wd_cnt;
        grant_nxt    = grant_id;
        tx_data_nxt  = tx_data;
        ack_nxt      = '0;
        tx_start_nxt = 1'b0;
        timeout_nxt  = 1'b0;
        finish       = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt    = win;
                    tx_data_nxt  = win_data;
                    tx_start_nxt = 1'b1;
                    wd_nxt       = WD_W'(TIMEOUT_CYCLES);
                    state_nxt    = START;
                end
            end
            START: begin
                // The start cycle already counts toward the watchdog window.
                if (wd_cnt != '0) wd_nxt = wd_cnt - WD_W'(1);
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done_tick) begin
                    finish = 1'b1;
                end else if (TIMEOUT_CYCLES != 0 && wd_cnt <= WD_W'(1)) begin
                    finish      = 1'b1;
                    timeout_nxt = 1'b1;
                end else if (wd_cnt != '0) begin
                    wd_nxt = wd_cnt - WD_W'(1);
                end
                if (finish) begin
                    ack_nxt[grant_id] = 1'b1;
                    wd_nxt            = '0;
                    if (32'(grant_id) == N_REQ - 1) ptr_nxt = '0;
                    else                            ptr_nxt = grant_id + ID_W'(1);
                    if (GAP_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        gap_nxt   = GAP_W'(GAP_CYCLES);
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt <= GAP_W'(1)) begin
                    gap_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State, counters and registered outputs; everything clears on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            gap_cnt     <= '0;
            wd_cnt      <= '0;
            ack         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            gap_cnt     <= gap_nxt;
            wd_cnt      <= wd_nxt;
            ack         <= ack_nxt;
            tx_start    <= tx_start_nxt;
            tx_data     <= tx_data_nxt;
            busy        <= busy_nxt;
            grant_id    <= grant_nxt;
            timeout_err <= timeout_nxt;
        end
    end

endmodule
